// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic/compare, iterative 1-bit-per-cycle shifter.
// Results are registered and presented over a valid/ready handshake.
module alu_exec_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_func,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero,
  output logic                  out_err
);
  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_XOR = 4'd2,  OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL = 4'd6,  OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_BGE = 4'd10, OP_BGEU = 4'd11;
  localparam logic [3:0] OP_EEE  = 4'd12;

  localparam logic [1:0] SH_LL = 2'd0, SH_RL = 2'd1, SH_RA = 2'd2;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state, state_next;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0]  shreg;
  logic [1:0]             sh_mode;

  logic                   accept, is_shift, long_shift, comb_err;
  logic [1:0]             mode_in;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  comb_res, shreg_step;

  function automatic logic [DATA_WIDTH-1:0] shift1(input logic [DATA_WIDTH-1:0] v,
                                                   input logic [1:0] mode);
    case (mode)
      SH_LL:   shift1 = {v[DATA_WIDTH-2:0], 1'b0};
      SH_RL:   shift1 = {1'b0, v[DATA_WIDTH-1:1]};
      default: shift1 = {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
    endcase
  endfunction

  assign accept     = in_valid && in_ready;
  assign shamt      = in_b[SHAMT_WIDTH-1:0];
  assign is_shift   = (alu_func == OP_SLL) || (alu_func == OP_SRL) || (alu_func == OP_SRA);
  assign long_shift = is_shift && (shamt > SHAMT_WIDTH'(1));
  assign mode_in    = (alu_func == OP_SLL) ? SH_LL : (alu_func == OP_SRL) ? SH_RL : SH_RA;
  assign shreg_step = shift1(shreg, sh_mode);

  // Single-cycle result; shifts here only ever see n of 0 or 1.
  always_comb begin
    comb_res = '0;
    comb_err = 1'b0;
    case (alu_func)
      OP_ADD:  comb_res = in_a + in_b;
      OP_SUB:  comb_res = in_a - in_b;
      OP_XOR:  comb_res = in_a ^ in_b;
      OP_OR:   comb_res = in_a | in_b;
      OP_AND:  comb_res = in_a & in_b;
      OP_SLL:  comb_res = in_a << shamt;
      OP_SRL:  comb_res = in_a >> shamt;
      OP_SRA:  comb_res = $signed(in_a) >>> shamt;
      OP_SLT:  comb_res[0] = $signed(in_a) < $signed(in_b);
      OP_SLTU: comb_res[0] = in_a < in_b;
      OP_BGE:  comb_res[0] = $signed(in_a) >= $signed(in_b);
      OP_BGEU: comb_res[0] = in_a >= in_b;
      default: comb_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && long_shift) state_next = SHIFT;
      SHIFT:   if (cnt == SHAMT_WIDTH'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) && (!out_valid || out_ready);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '0;
      shreg      <= '0;
      sh_mode    <= SH_LL;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (state == IDLE && accept) begin
        if (long_shift) begin
          shreg   <= shift1(in_a, mode_in);
          cnt     <= shamt - SHAMT_WIDTH'(1);
          sh_mode <= mode_in;
        end else begin
          out_valid  <= 1'b1;
          out_result <= comb_res;
          out_zero   <= (comb_res == '0);
          out_err    <= comb_err;
        end
      end else if (state == SHIFT) begin
        shreg <= shreg_step;
        cnt   <= cnt - SHAMT_WIDTH'(1);
        if (cnt == SHAMT_WIDTH'(1)) begin
          out_valid  <= 1'b1;
          out_result <= shreg_step;
          out_zero   <= (shreg_step == '0);
          out_err    <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed plus randomized checks of alu_exec_unit against a plain-arithmetic reference model.
module tb_alu_exec_unit;
  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_XOR = 4'd2,  OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL = 4'd6,  OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_BGE = 4'd10, OP_BGEU = 4'd11;
  localparam logic [3:0] OP_EEE  = 4'd12;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [3:0]  alu_func = '0;
  logic [31:0] in_a = '0, in_b = '0, out_result;
  logic        out_zero, out_err;
  int          checks = 0, errors = 0;

  alu_exec_unit #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .alu_func(alu_func), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero), .out_err(out_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: result, error flag and latency straight from the operation rules.
  task automatic model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic e, output int lat);
    int n;
    n = int'(b % 32);
    e = 1'b0; lat = 1;
    case (f)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_SLL:  begin r = a << n; if (n > 1) lat = n; end
      OP_SRL:  begin r = a >> n; if (n > 1) lat = n; end
      OP_SRA:  begin r = 32'($signed(a) >>> n); if (n > 1) lat = n; end
      OP_SLT:  r = ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: r = (a < b)  ? 32'd1 : 32'd0;
      OP_BGE:  r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      OP_BGEU: r = (a >= b) ? 32'd1 : 32'd0;
      default: begin r = 32'd0; e = 1'b1; end
    endcase
  endtask

  // Issue one op, wait for its result, check value/flags/latency, optionally stall the consumer.
  task automatic do_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input int stall);
    logic [31:0] er; logic ee; int el, lat, busy, guard;
    model(f, a, b, er, ee, el);
    @(negedge clk);
    in_valid = 1'b1; alu_func = f; in_a = a; in_b = b;
    guard = 0;
    while (!in_ready && guard < 40) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; alu_func = 4'($urandom);
    lat = 1; busy = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) busy++;
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(el));
    chk({tag, "_res"}, out_result, er);
    chk({tag, "_zero"}, 32'(out_zero), 32'(er == 32'd0));
    chk({tag, "_err"}, 32'(out_err), 32'(ee));
    if (el > 1) chk({tag, "_busy"}, 32'(busy), 32'(el - 1));
    if (stall > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        chk({tag, "_hold_v"}, 32'(out_valid), 32'd1);
        chk({tag, "_hold_r"}, out_result, er);
        chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] er; logic ee; int el, seen;
    // Reset state, including in_ready while rstn is held low.
    repeat (2) @(negedge clk);
    chk("rst_ready_low", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", {30'd0, out_zero, out_err}, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    do_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("sub_neg", OP_SUB, 32'd5, 32'd7, 0);
    do_op("slt", OP_SLT, 32'h8000_0000, 32'd1, 0);
    do_op("sltu", OP_SLTU, 32'h8000_0000, 32'd1, 0);
    do_op("bge_eq", OP_BGE, 32'd3, 32'd3, 0);
    do_op("bgeu", OP_BGEU, 32'd0, 32'hFFFF_FFFF, 0);
    do_op("sra31", OP_SRA, 32'h8000_0000, 32'h3F, 0);
    do_op("srl31", OP_SRL, 32'h8000_0000, 32'h1F, 0);
    do_op("sll0", OP_SLL, 32'd1, 32'hFFFF_FFE0, 0);
    do_op("sll1", OP_SLL, 32'h8000_0001, 32'd1, 0);
    do_op("srl2", OP_SRL, 32'hF000_0000, 32'd2, 0);
    do_op("eee", OP_EEE, 32'd9, 32'd9, 0);
    do_op("after_eee", OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
    do_op("undef15", 4'd15, 32'd1, 32'd2, 0);

    // Backpressure: XOR result held, OR accepted on the release edge.
    do_op("xor_bp", OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 4);
    chk("bp_xor_val", out_result, 32'h0F0F_F0F0);
    out_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; alu_func = OP_OR; in_a = 32'h1200_0000; in_b = 32'h0000_0034;
    #1 chk("bp_ready_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_or_valid", 32'(out_valid), 32'd1);
    chk("bp_or_res", out_result, 32'h1200_0034);

    // Reset in the middle of a long shift.
    @(negedge clk);
    in_valid = 1'b1; alu_func = OP_SLL; in_a = 32'hDEAD_BEEF; in_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", out_result, 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rstn = 1'b1;
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("midrst_no_valid", 32'(seen), 32'd0);
    do_op("post_rst_add", OP_ADD, 32'd2, 32'd3, 0);

    // Random ops: all codes, full-width operands, occasional consumer stalls.
    for (int i = 0; i < 150; i++) begin
      logic [3:0] f; logic [31:0] a, b;
      f = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      do_op("rand", f, a, b, ($urandom_range(0, 5) == 0) ? 2 : 0);
    end
    model(OP_ADD, 32'd0, 32'd0, er, ee, el);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
